// File: rtl/shared_memory_arbiter_if.sv
// Request/response bus between NUM_PORTS masters and shared_memory_arbiter.
// Per-port fields are packed side by side; port p owns slice p.
interface shared_memory_arbiter_if #(
  parameter int NUM_PORTS   = 2,
  parameter int ADRESS_SIZE = 32,
  parameter int WORD_SIZE   = 32
);
  logic [NUM_PORTS-1:0]             ReqValid;
  logic [NUM_PORTS-1:0]             ReqReady;
  logic [NUM_PORTS-1:0]             ReqWrite;
  logic [NUM_PORTS-1:0]             ReqLock;
  logic [NUM_PORTS*WORD_SIZE/8-1:0] ReqByteEn;
  logic [NUM_PORTS*ADRESS_SIZE-1:0] ReqAdr;
  logic [NUM_PORTS*WORD_SIZE-1:0]   ReqWriteData;
  logic [NUM_PORTS-1:0]             RspValid;
  logic [WORD_SIZE-1:0]             RspData;

  modport master (
    output ReqValid, ReqWrite, ReqLock, ReqByteEn, ReqAdr, ReqWriteData,
    input  ReqReady, RspValid, RspData
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqLock, ReqByteEn, ReqAdr, ReqWriteData,
    output ReqReady, RspValid, RspData
  );
endinterface

// File: rtl/shared_memory_arbiter.sv
// Single-ported word memory shared by NUM_PORTS channels via a lockable round-robin arbiter.
// Define SHARED_MEM_FIXED_PRIORITY_EN to replace round-robin with fixed priority (port 0 highest).
module shared_memory_arbiter #(
  parameter string MEMORY_FILE_PATH  = "",
  parameter int    MEMORY_SIZE_WORDS = 64,
  parameter int    ADRESS_SIZE       = 32,
  parameter int    WORD_SIZE         = 32,
  parameter int    NUM_PORTS         = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  shared_memory_arbiter_if.slave bus
);
  localparam int BYTES    = WORD_SIZE / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W    = (MEMORY_SIZE_WORDS > 1) ? $clog2(MEMORY_SIZE_WORDS) : 1;
  localparam int PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_e;

  logic [WORD_SIZE-1:0] r_mem [MEMORY_SIZE_WORDS];

  lock_state_e          r_state;
  lock_state_e          w_stateNext;
  logic [PTR_W-1:0]     r_owner;
  logic [PTR_W-1:0]     w_ownerNext;
  logic                 w_lockActive;

  logic [PTR_W-1:0]     w_start;
  logic [NUM_PORTS-1:0] w_grant;
  logic [PTR_W-1:0]     w_gIdx;
  logic                 w_xfer;
  logic                 w_isWrite;
  logic [BYTES-1:0]     w_byteEn;
  logic [WORD_SIZE-1:0] w_wrData;
  logic [IDX_W-1:0]     w_wordIdx;

  logic [NUM_PORTS-1:0] r_rspValid;
  logic [WORD_SIZE-1:0] r_rspData;

  initial begin
    for (int i = 0; i < MEMORY_SIZE_WORDS; i++) begin
      r_mem[i] = '0;
    end
  end

`ifdef SHARED_MEM_FIXED_PRIORITY_EN
  assign w_start = '0;
`else
  logic [PTR_W-1:0] r_rrPtr;

  assign w_start = r_rrPtr;

  // Under lock only the owner transfers, so this keeps pointing just past the owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rrPtr <= '0;
    end else if (w_xfer) begin
      r_rrPtr <= (int'(w_gIdx) == NUM_PORTS - 1) ? '0 : w_gIdx + 1'b1;
    end
  end
`endif

  // The lock stops binding once the owner has dropped both valid and lock.
  assign w_lockActive = (r_state == ST_LOCKED) &&
                        (bus.ReqValid[r_owner] || bus.ReqLock[r_owner]);

  always_comb begin
    int   cand;
    logic found;
    w_grant = '0;
    w_gIdx  = '0;
    cand    = 0;
    found   = 1'b0;
    if (!reset) begin
      if (w_lockActive) begin
        w_grant[r_owner] = bus.ReqValid[r_owner];
        w_gIdx           = r_owner;
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          cand = int'(w_start) + k;
          if (cand >= NUM_PORTS) begin
            cand = cand - NUM_PORTS;
          end
          if (!found && bus.ReqValid[PTR_W'(cand)]) begin
            found                  = 1'b1;
            w_grant[PTR_W'(cand)] = 1'b1;
            w_gIdx                 = PTR_W'(cand);
          end
        end
      end
    end
  end

  assign w_xfer    = |w_grant;
  assign w_isWrite = bus.ReqWrite[w_gIdx];
  assign w_byteEn  = bus.ReqByteEn[int'(w_gIdx)*BYTES +: BYTES];
  assign w_wrData  = bus.ReqWriteData[int'(w_gIdx)*WORD_SIZE +: WORD_SIZE];
  assign w_wordIdx = bus.ReqAdr[int'(w_gIdx)*ADRESS_SIZE + ADDR_LSB +: IDX_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_stateNext;
      r_owner <= w_ownerNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    if (w_lockActive) begin
      if (w_xfer && !bus.ReqLock[r_owner]) begin
        w_stateNext = ST_IDLE;
      end
    end else if (w_xfer && bus.ReqLock[w_gIdx]) begin
      w_stateNext = ST_LOCKED;
      w_ownerNext = w_gIdx;
    end else begin
      w_stateNext = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer && w_isWrite) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_byteEn[b]) begin
          r_mem[w_wordIdx][b*8 +: 8] <= w_wrData[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rspValid <= '0;
    end else if (w_xfer && !w_isWrite) begin
      r_rspValid <= w_grant;
    end else begin
      r_rspValid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer && !w_isWrite) begin
      r_rspData <= r_mem[w_wordIdx];
    end
  end

  // A response due in the reset cycle is dropped.
  assign bus.ReqReady = w_grant;
  assign bus.RspValid = reset ? '0 : r_rspValid;
  assign bus.RspData  = r_rspData;

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Directed bench for shared_memory_arbiter: a transaction-level model checks every cycle,
// and literal expectations from the test plan pin key points.
module tb_shared_memory_arbiter;
  localparam int NP    = 2;
  localparam int AW    = 32;
  localparam int WS    = 32;
  localparam int DEPTH = 64;
  localparam int BE    = WS / 8;

  logic clk = 1'b0;
  logic reset;

  shared_memory_arbiter_if #(.NUM_PORTS(NP), .ADRESS_SIZE(AW), .WORD_SIZE(WS)) bus ();

  shared_memory_arbiter #(
    .MEMORY_FILE_PATH (""),
    .MEMORY_SIZE_WORDS(DEPTH),
    .ADRESS_SIZE      (AW),
    .WORD_SIZE        (WS),
    .NUM_PORTS        (NP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  bit            pValid [NP];
  bit            pWrite [NP];
  bit            pLock  [NP];
  logic [AW-1:0] pAdr   [NP];
  logic [WS-1:0] pData  [NP];
  logic [BE-1:0] pBe    [NP];

  logic [WS-1:0] mMem [DEPTH];
  int            mPtr;
  int            mOwner;
  bit            mRsp [NP];
  logic [WS-1:0] mData;
  bit            mDataKnown;

  logic [NP-1:0] obsReady;
  logic [NP-1:0] obsRspValid;
  logic [WS-1:0] obsRspData;
  int            dutGrants[$];

`ifdef SHARED_MEM_FIXED_PRIORITY_EN
  int rrExp[6] = '{0, 0, 0, 0, 0, 0};
`else
  int rrExp[6] = '{0, 1, 0, 1, 0, 1};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic setPort(input int p, input bit v, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [WS-1:0] d, input logic [BE-1:0] be);
    pValid[p] = v; pWrite[p] = w; pLock[p] = l; pAdr[p] = a; pData[p] = d; pBe[p] = be;
    bus.ReqValid[p] = v;
    bus.ReqWrite[p] = w;
    bus.ReqLock[p]  = l;
    bus.ReqAdr[p*AW +: AW]       = a;
    bus.ReqWriteData[p*WS +: WS] = d;
    bus.ReqByteEn[p*BE +: BE]    = be;
  endtask

  task automatic idlePort(input int p);
    setPort(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic readPort(input int p, input logic [AW-1:0] a, input bit l);
    setPort(p, 1'b1, 1'b0, l, a, '0, '0);
  endtask

  task automatic writePort(input int p, input logic [AW-1:0] a, input logic [WS-1:0] d,
                           input logic [BE-1:0] be);
    setPort(p, 1'b1, 1'b1, 1'b0, a, d, be);
  endtask

  // Which port the rules say gets the slot this cycle (-1 = none).
  function automatic int mdlGrant();
    if (reset) return -1;
    if (mOwner >= 0 && (pValid[mOwner] || pLock[mOwner])) return pValid[mOwner] ? mOwner : -1;
    for (int k = 0; k < NP; k++) begin
`ifdef SHARED_MEM_FIXED_PRIORITY_EN
      int p = k;
`else
      int p = (mPtr + k) % NP;
`endif
      if (pValid[p]) return p;
    end
    return -1;
  endfunction

  task automatic modelAdvance(input int g);
    bit active;
    int idx;
    if (reset) begin
      mPtr = 0;
      mOwner = -1;
      for (int p = 0; p < NP; p++) mRsp[p] = 1'b0;
      return;
    end
    active = (mOwner >= 0) && (pValid[mOwner] || pLock[mOwner]);
    for (int p = 0; p < NP; p++) mRsp[p] = 1'b0;
    if (g >= 0) begin
      idx = int'((pAdr[g] / BE) % DEPTH);
      if (pWrite[g]) begin
        for (int b = 0; b < BE; b++)
          if (pBe[g][b]) mMem[idx][b*8 +: 8] = pData[g][b*8 +: 8];
      end else begin
        mRsp[g] = 1'b1;
        mData = mMem[idx];
        mDataKnown = 1'b1;
      end
      mPtr = (g + 1) % NP;
    end
    if (active) begin
      if (g >= 0 && !pLock[g]) mOwner = -1;
    end else begin
      mOwner = (g >= 0 && pLock[g]) ? g : -1;
    end
  endtask

  task automatic checkOutput(input int g);
    logic [NP-1:0] expReady;
    logic [NP-1:0] expRsp;
    expReady = '0;
    expRsp   = '0;
    obsReady    = bus.ReqReady;
    obsRspValid = bus.RspValid;
    obsRspData  = bus.RspData;
    for (int p = 0; p < NP; p++) if (obsReady[p]) dutGrants.push_back(p);
    if (g >= 0) expReady[g] = 1'b1;
    if (!reset) for (int p = 0; p < NP; p++) expRsp[p] = mRsp[p];
    check("ReqReady", 32'(obsReady), 32'(expReady));
    check("RspValid", 32'(obsRspValid), 32'(expRsp));
    if (mDataKnown) check("RspData", obsRspData, mData);
  endtask

  // Inputs are set just after a falling edge; outputs settle, get checked, then the edge passes.
  task automatic applyStimulus();
    int g;
    #1;
    g = mdlGrant();
    checkOutput(g);
    modelAdvance(g);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
    mPtr = 0;
    mOwner = -1;
    mDataKnown = 1'b0;
    for (int p = 0; p < NP; p++) mRsp[p] = 1'b0;
    reset = 1'b1;
    for (int p = 0; p < NP; p++) idlePort(p);
    @(negedge clk);
    applyStimulus();
    applyStimulus();
    reset = 1'b0;

    // Write then read back one word.
    writePort(0, 32'h10, 32'hDEADBEEF, 4'hF); applyStimulus();
    readPort(0, 32'h10, 1'b0);                applyStimulus();
    idlePort(0);                              applyStimulus();
    check("t1 RspValid", 32'(obsRspValid), 32'h1);
    check("t1 RspData", obsRspData, 32'hDEADBEEF);

    // Partial byte write and address aliasing.
    writePort(0, 32'h20, 32'h11223344, 4'hF);  applyStimulus();
    writePort(0, 32'h20, 32'h000000AA, 4'h1);  applyStimulus();
    readPort(0, 32'h20, 1'b0);                 applyStimulus();
    readPort(0, 32'h120, 1'b0);                applyStimulus();
    check("t2 RspData", obsRspData, 32'h112233AA);
    idlePort(0);                               applyStimulus();
    check("t2 alias RspData", obsRspData, 32'h112233AA);
    writePort(1, 32'h20, 32'hFFFFFFFF, 4'h0);  applyStimulus();
    readPort(1, 32'h20, 1'b0);                 applyStimulus();
    idlePort(1);                               applyStimulus();
    check("t2 be0 RspValid", 32'(obsRspValid), 32'h2);
    check("t2 be0 RspData", obsRspData, 32'h112233AA);

    // Two continuous requesters right after reset.
    reset = 1'b1; applyStimulus(); reset = 1'b0;
    dutGrants.delete();
    readPort(0, 32'h10, 1'b0);
    readPort(1, 32'h20, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus();
    check("t3 grant count", 32'(dutGrants.size()), 32'd6);
    if (dutGrants.size() == 6)
      for (int i = 0; i < 6; i++) check("t3 grant order", 32'(dutGrants[i]), 32'(rrExp[i]));

    // Port 1 holds a lock for three transfers, releases on the fourth.
    idlePort(0);
    readPort(1, 32'h20, 1'b1); applyStimulus();
    check("t4 lock0 ReqReady", 32'(obsReady), 32'h2);
    readPort(0, 32'h10, 1'b0);
    applyStimulus(); check("t4 lock1 ReqReady", 32'(obsReady), 32'h2);
    applyStimulus(); check("t4 lock2 ReqReady", 32'(obsReady), 32'h2);
    readPort(1, 32'h20, 1'b0);
    applyStimulus(); check("t4 release ReqReady", 32'(obsReady), 32'h2);
    applyStimulus(); check("t4 after ReqReady", 32'(obsReady), 32'h1);

    // Locked owner goes idle while holding, then drops both valid and lock.
    idlePort(0);
    readPort(1, 32'h20, 1'b1);                    applyStimulus();
    readPort(0, 32'h10, 1'b0);
    setPort(1, 1'b0, 1'b0, 1'b1, 32'h20, '0, '0); applyStimulus();
    check("t5 held ReqReady", 32'(obsReady), 32'h0);
    idlePort(1);                                  applyStimulus();
    check("t5 drop ReqReady", 32'(obsReady), 32'h1);
    idlePort(0);                                  applyStimulus();

    // Reset right after a read acceptance.
    readPort(0, 32'h20, 1'b0); applyStimulus();
    idlePort(0);
    reset = 1'b1;              applyStimulus();
    check("t6 reset RspValid", 32'(obsRspValid), 32'h0);
    reset = 1'b0;
    readPort(0, 32'h10, 1'b0);
    readPort(1, 32'h20, 1'b0); applyStimulus();
    check("t6 post ReqReady", 32'(obsReady), 32'h1);
    check("t6 post RspValid", 32'(obsRspValid), 32'h0);
    idlePort(0);
    idlePort(1);               applyStimulus();
    check("t6 keep RspValid", 32'(obsRspValid), 32'h1);
    check("t6 keep RspData", obsRspData, 32'hDEADBEEF);
    applyStimulus();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
